// File: rtl/iir_coef_pkg.sv
// Shared constants, FSM encoding and saturation helper for the IIR
// coefficient precompute stage and the filter datapath it feeds.
package iir_coef_pkg;

  localparam int DW     = 12;  // coefficient width, signed Q1.FRAC
  localparam int FRAC   = 11;  // fractional bits, always DW-1
  localparam int STEP_W = 3;   // wide enough to count the five products

  localparam logic [STEP_W-1:0] STEP_LAST = 3'd4;

  // FSM encoding kept as plain constants so older tools can share it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_SUB  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Clamp a DW+1-bit signed value into the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] x);
    logic signed [DW-1:0] r;
    if (x[DW] != x[DW-1]) begin
      r = x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      r = x[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/iir_coef_precompute_if.sv
// Load/coefficient bus between the coefficient source (master) and the
// precompute stage (slave).
interface iir_coef_precompute_if;
  import iir_coef_pkg::*;

  logic                 load;
  logic signed [DW-1:0] a1, a2, b0, b1, b2;
  logic                 busy;
  logic                 coef_valid;
  logic                 load_drop;
  logic signed [DW-1:0] a1a1, a1a2, a1b0, a1b1, a1b2, a0a1;

  modport master (
    output load, a1, a2, b0, b1, b2,
    input  busy, coef_valid, load_drop,
    input  a1a1, a1a2, a1b0, a1b1, a1b2, a0a1
  );

  modport slave (
    input  load, a1, a2, b0, b1, b2,
    output busy, coef_valid, load_drop,
    output a1a1, a1a2, a1b0, a1b1, a1b2, a0a1
  );
endinterface

// File: rtl/iir_qmul.sv
// Combinational Q1.FRAC x Q1.FRAC multiply: full signed product, optional
// round-half-up, arithmetic shift back to Q1.FRAC, saturate to DW bits.
// Build option: define COEF_ROUND_EN to add the rounding constant; without
// it the shift truncates toward -inf and no adder is built.
module iir_qmul
  import iir_coef_pkg::*;
(
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic signed [DW-1:0] o_p
);

  localparam int PW = 2*DW + 1;
  localparam logic signed [PW-1:0] MAX_V = PW'((1 << (DW-1)) - 1);
  localparam logic signed [PW-1:0] MIN_V = -PW'(1 << (DW-1));

  logic signed [2*DW-1:0] w_prod;
  logic signed [PW-1:0]   w_adj;
  logic signed [PW-1:0]   w_shift;

  assign w_prod = i_a * i_b;

`ifdef COEF_ROUND_EN
  localparam logic signed [PW-1:0] HALF_LSB = PW'(1) << (FRAC-1);
  assign w_adj = PW'(w_prod) + HALF_LSB;
`else
  assign w_adj = PW'(w_prod);
`endif

  assign w_shift = w_adj >>> FRAC;

  // Only -1 * -1 can exceed the range; the low clamp is kept for symmetry.
  always_comb begin
    if (w_shift > MAX_V) begin
      o_p = MAX_V[DW-1:0];
    end else if (w_shift < MIN_V) begin
      o_p = MIN_V[DW-1:0];
    end else begin
      o_p = w_shift[DW-1:0];
    end
  end

endmodule

// File: rtl/iir_coef_precompute.sv
// Lookahead coefficient precompute: captures a1,a2,b0,b1,b2 on load, forms
// a1*{a1,a2,b0,b1,b2} on one shared multiplier (one per cycle) into shadow
// registers, then a0a1 = sat(a1a1 - a2), and publishes all six at once.
// Build option: COEF_ROUND_EN selects rounding in the multiplier.
module iir_coef_precompute
  import iir_coef_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  iir_coef_precompute_if.slave    bus
);

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic                r_busy;
  logic                r_valid;
  logic                r_drop;

  logic signed [DW-1:0] r_op_a1, r_op_a2, r_op_b0, r_op_b1, r_op_b2;
  logic signed [DW-1:0] r_sh_a1a1, r_sh_a1a2, r_sh_a1b0, r_sh_a1b1, r_sh_a1b2, r_sh_a0a1;
  logic signed [DW-1:0] r_a1a1, r_a1a2, r_a1b0, r_a1b1, r_a1b2, r_a0a1;

  logic signed [DW-1:0] w_mul_b;
  logic signed [DW-1:0] w_prod;
  logic signed [DW:0]   w_diff;

  // Second multiplier operand selected by the product step.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_mul_b = r_op_a1;
    case (r_step)
      3'd0:    w_mul_b = r_op_a1;
      3'd1:    w_mul_b = r_op_a2;
      3'd2:    w_mul_b = r_op_b0;
      3'd3:    w_mul_b = r_op_b1;
      3'd4:    w_mul_b = r_op_b2;
      default: w_mul_b = r_op_a1;
    endcase
  end

  iir_qmul u_qmul (
    .i_a (r_op_a1),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  assign w_diff = {r_sh_a1a1[DW-1], r_sh_a1a1} - {r_op_a2[DW-1], r_op_a2};

  // Control FSM, operand capture, shadow products and atomic output update.
  // NOTE: state uses non-blocking assignments and a synchronous reset that also clears the shadows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_drop    <= 1'b0;
      r_op_a1   <= '0;
      r_op_a2   <= '0;
      r_op_b0   <= '0;
      r_op_b1   <= '0;
      r_op_b2   <= '0;
      r_sh_a1a1 <= '0;
      r_sh_a1a2 <= '0;
      r_sh_a1b0 <= '0;
      r_sh_a1b1 <= '0;
      r_sh_a1b2 <= '0;
      r_sh_a0a1 <= '0;
      r_a1a1    <= '0;
      r_a1a2    <= '0;
      r_a1b0    <= '0;
      r_a1b1    <= '0;
      r_a1b2    <= '0;
      r_a0a1    <= '0;
    end else begin
      // A load during the computing states is dropped and flagged; during
      // DONE it is simply left for IDLE to sample on the next cycle.
      r_drop <= bus.load && ((r_state == ST_MUL) || (r_state == ST_SUB));

      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            r_op_a1 <= bus.a1;
            r_op_a2 <= bus.a2;
            r_op_b0 <= bus.b0;
            r_op_b1 <= bus.b1;
            r_op_b2 <= bus.b2;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_state <= ST_MUL;
          end
        end

        ST_MUL: begin
          case (r_step)
            3'd0:    r_sh_a1a1 <= w_prod;
            3'd1:    r_sh_a1a2 <= w_prod;
            3'd2:    r_sh_a1b0 <= w_prod;
            3'd3:    r_sh_a1b1 <= w_prod;
            default: r_sh_a1b2 <= w_prod;
          endcase
          if (r_step == STEP_LAST) begin
            r_state <= ST_SUB;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end

        ST_SUB: begin
          r_sh_a0a1 <= sat_dw(w_diff);
          r_state   <= ST_DONE;
        end

        default: begin  // ST_DONE
          r_a1a1  <= r_sh_a1a1;
          r_a1a2  <= r_sh_a1a2;
          r_a1b0  <= r_sh_a1b0;
          r_a1b1  <= r_sh_a1b1;
          r_a1b2  <= r_sh_a1b2;
          r_a0a1  <= r_sh_a0a1;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.coef_valid = r_valid;
  assign bus.load_drop  = r_drop;
  assign bus.a1a1       = r_a1a1;
  assign bus.a1a2       = r_a1a2;
  assign bus.a1b0       = r_a1b0;
  assign bus.a1b1       = r_a1b1;
  assign bus.a1b2       = r_a1b2;
  assign bus.a0a1       = r_a0a1;

endmodule

// File: tb/tb_iir_coef_precompute.sv
// Directed bench for iir_coef_precompute; expected values are hand-computed
// and select the rounding variants when COEF_ROUND_EN is defined.
module tb_iir_coef_precompute;
  import iir_coef_pkg::*;

`ifdef COEF_ROUND_EN
  localparam logic [DW-1:0] EXP_SMALL_B0 = 12'h001;  // 0x001 * 0x400
  localparam logic [DW-1:0] EXP_NEG_B0   = 12'h000;  // 0xFFF * 0x400
  localparam logic [DW-1:0] EXP_MIX_B0   = 12'hC01;  // 0xC00 * 0x7FF
  localparam logic [DW-1:0] EXP_MIX_B2   = 12'h000;  // 0xC00 * 0x001
`else
  localparam logic [DW-1:0] EXP_SMALL_B0 = 12'h000;
  localparam logic [DW-1:0] EXP_NEG_B0   = 12'hFFF;
  localparam logic [DW-1:0] EXP_MIX_B0   = 12'hC00;
  localparam logic [DW-1:0] EXP_MIX_B2   = 12'hFFF;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  iir_coef_precompute_if bus ();

  iir_coef_precompute dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_set(input string tag,
                           input logic [DW-1:0] e_a1a1, input logic [DW-1:0] e_a1a2,
                           input logic [DW-1:0] e_a1b0, input logic [DW-1:0] e_a1b1,
                           input logic [DW-1:0] e_a1b2, input logic [DW-1:0] e_a0a1);
    check({tag, ".a1a1"}, 16'($unsigned(bus.a1a1)), 16'(e_a1a1));
    check({tag, ".a1a2"}, 16'($unsigned(bus.a1a2)), 16'(e_a1a2));
    check({tag, ".a1b0"}, 16'($unsigned(bus.a1b0)), 16'(e_a1b0));
    check({tag, ".a1b1"}, 16'($unsigned(bus.a1b1)), 16'(e_a1b1));
    check({tag, ".a1b2"}, 16'($unsigned(bus.a1b2)), 16'(e_a1b2));
    check({tag, ".a0a1"}, 16'($unsigned(bus.a0a1)), 16'(e_a0a1));
  endtask

  task automatic set_inputs(input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                            input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                            input logic [DW-1:0] b2);
    bus.a1 = a1;
    bus.a2 = a2;
    bus.b0 = b0;
    bus.b1 = b1;
    bus.b2 = b2;
  endtask

  // From just after the load edge, count edges until coef_valid, checking
  // busy stays high meanwhile and drops with the result.
  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (!bus.coef_valid && n < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, ".latency"}, 16'(n), 16'(exp_lat));
    check({tag, ".busy_hold"}, 16'(busy_ok), 16'd1);
    check({tag, ".busy_end"}, 16'(bus.busy), 16'd0);
  endtask

  // One complete load; inputs are scrambled right after the load edge.
  task automatic run_load(input string tag,
                          input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                          input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                          input logic [DW-1:0] b2);
    set_inputs(a1, a2, b0, b1, b2);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    set_inputs(12'h5A5, 12'h3C3, 12'h7E1, 12'h812, 12'h0F0);
    check({tag, ".busy_start"}, 16'(bus.busy), 16'd1);
    check({tag, ".valid_clear"}, 16'(bus.coef_valid), 16'd0);
    wait_result(tag, 7);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.load = 1'b0;
    set_inputs('0, '0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst.busy", 16'(bus.busy), 16'd0);
    check("rst.valid", 16'(bus.coef_valid), 16'd0);
    check("rst.drop", 16'(bus.load_drop), 16'd0);
    check_set("rst", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);

    // Basic set: 0.5 and 0.125 products.
    run_load("t1", 12'h400, 12'h100, 12'h400, 12'h400, 12'h400);
    check_set("t1", 12'h200, 12'h080, 12'h200, 12'h200, 12'h200, 12'h100);

    // -1 * -1 saturates; subtract saturates high.
    run_load("t2", 12'h800, 12'h800, 12'h000, 12'h000, 12'h000);
    check_set("t2", 12'h7FF, 12'h7FF, 12'h000, 12'h000, 12'h000, 12'h7FF);

    // Rounding vs truncation on small and negative products.
    run_load("t3a", 12'h001, 12'h000, 12'h400, 12'h000, 12'h000);
    check_set("t3a", 12'h000, 12'h000, EXP_SMALL_B0, 12'h000, 12'h000, 12'h000);
    run_load("t3b", 12'hFFF, 12'h000, 12'h400, 12'h000, 12'h000);
    check_set("t3b", 12'h000, 12'h000, EXP_NEG_B0, 12'h000, 12'h000, 12'h000);

    // Mixed signs: a1=-0.5, a2=-0.25.
    run_load("mix", 12'hC00, 12'hE00, 12'h7FF, 12'hA00, 12'h001);
    check_set("mix", 12'h200, 12'h100, EXP_MIX_B0, 12'h300, EXP_MIX_B2, 12'h400);

    // Load while busy is dropped and flagged for one cycle.
    set_inputs(12'h400, 12'h100, 12'h400, 12'h400, 12'h400);
    bus.load = 1'b1;
    tick();                                        // edge k
    bus.load = 1'b0;
    tick();                                        // k+1
    tick();                                        // k+2
    set_inputs(12'h800, 12'h800, 12'h000, 12'h000, 12'h000);
    bus.load = 1'b1;
    tick();                                        // k+3
    bus.load = 1'b0;
    check("t4.drop_pulse", 16'(bus.load_drop), 16'd1);
    tick();                                        // k+4
    check("t4.drop_end", 16'(bus.load_drop), 16'd0);
    wait_result("t4", 3);
    check_set("t4", 12'h200, 12'h080, 12'h200, 12'h200, 12'h200, 12'h100);

    // Reset mid-run discards everything.
    set_inputs(12'hC00, 12'hE00, 12'h7FF, 12'hA00, 12'h001);
    bus.load = 1'b1;
    tick();                                        // edge k
    bus.load = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();                                        // k+4
    rst = 1'b0;
    check("t5.busy", 16'(bus.busy), 16'd0);
    check("t5.valid", 16'(bus.coef_valid), 16'd0);
    check_set("t5", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
    tick();
    tick();
    check("t5.idle_valid", 16'(bus.coef_valid), 16'd0);
    run_load("t5r", 12'h400, 12'h100, 12'h400, 12'h400, 12'h400);
    check_set("t5r", 12'h200, 12'h080, 12'h200, 12'h200, 12'h200, 12'h100);

    // Load held high: a result every 8 cycles; new inputs after the load
    // edge only matter for the following capture.
    set_inputs(12'hC00, 12'hE00, 12'h7FF, 12'hA00, 12'h001);
    bus.load = 1'b1;
    tick();                                        // edge k
    set_inputs(12'h800, 12'h800, 12'h000, 12'h000, 12'h000);
    wait_result("t6a", 7);
    check_set("t6a", 12'h200, 12'h100, EXP_MIX_B0, 12'h300, EXP_MIX_B2, 12'h400);
    tick();                                        // k+8: reloaded
    check("t6.valid_low", 16'(bus.coef_valid), 16'd0);
    check("t6.busy_high", 16'(bus.busy), 16'd1);
    bus.load = 1'b0;
    wait_result("t6b", 7);
    check_set("t6b", 12'h7FF, 12'h7FF, 12'h000, 12'h000, 12'h000, 12'h7FF);

    // Outputs and coef_valid hold while idle.
    tick();
    tick();
    tick();
    check("hold.valid", 16'(bus.coef_valid), 16'd1);
    check("hold.a1a1", 16'($unsigned(bus.a1a1)), 16'h7FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
